nibble_shift_sequencer: RTL and testbench
=========================================

# nibble_shift_sequencer

Multi-cycle, nibble-serial controller for the approximate alphabet-set multiplier datapath. It accepts one unsigned activation/weight pair per handshake and splits the weight into NIBBLE_WIDTH-bit nibbles. Each nibble is mapped to an alphabet {1,3,5,7} plus a shift SL, and the block drives one shift-and-accumulate step per nibble into a 2·WIDTH-bit accumulator. It sits between the PE operand registers and the PE accumulator, and sequences the shared shift datapath instead of replicating it per nibble.

## Interface
Parameters:
- LOG2_WIDTH, 4, log2 of operand width
- WIDTH, 2**LOG2_WIDTH, activation/weight width
- LOG2_NIBBLE_WIDTH, 2, log2 of nibble width (only 2 is supported)
- NIBBLE_WIDTH, 2**LOG2_NIBBLE_WIDTH, weight nibble width
- NUM_NIBBLES, WIDTH/NIBBLE_WIDTH, nibbles per weight

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- act  in  WIDTH  unsigned activation
- wgt  in  WIDTH  unsigned weight
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  accumulated approximate product
- approx  out  1  at least one nibble was approximated
- busy  out  1  high in RUN or DONE
- nib_idx  out  LOG2_WIDTH  index of the nibble processed this cycle (debug)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch act and wgt, clear acc and approx, set k=0 (or the first nonzero nibble, see Configuration), go to RUN.
- RUN: each cycle processes nibble k = wgt[NIBBLE_WIDTH*k +: NIBBLE_WIDTH].
  - Mapping: nibble 0 adds nothing.
  - Exact mapping: an exact nibble v = alpha·2^SL with odd alpha ≤ 7 and SL = trailing-zero count (0..3).
  - Approximated nibbles, which set approx: 9→8 (alpha 1, SL 3), 11→12 (3, 2), 13→12 (3, 2), 15→14 (7, 1).
  - IX = alpha·act, WIDTH+3 bits, formed by shift-add (3·act = (act<<1)+act, and so on).
  - acc += IX << (NIBBLE_WIDTH·k + SL), truncated to 2·WIDTH bits. This never overflows, because the maximum effective weight is 0xEEEE for WIDTH=16.
  - After the last nibble, go to DONE.
- DONE:
  - out_valid=1 and product=acc.
  - On out_ready, go to IDLE.
  - product and approx are held stable until the handshake completes.
- in_ready=0 outside IDLE. in_valid is ignored while busy.

## Timing
- Reset values: in_ready=0 during rst and 1 in the first cycle after it. out_valid=0, product=0, approx=0, busy=0, nib_idx=0, state=IDLE.
- Accept edge E0, where in_valid && in_ready.
  - RUN occupies edges E0+1 … E0+NUM_NIBBLES.
  - out_valid is high in the cycle following edge E0+NUM_NIBBLES, which gives a latency of NUM_NIBBLES+1 cycles.
- Output handshake completes on the edge where out_valid && out_ready. in_ready rises in the next cycle, so there is a minimum one-cycle bubble between jobs.
- out_ready held low stalls indefinitely in DONE, with no data loss.
- rst asserted in any state, including mid-RUN: on the next edge, state=IDLE and all outputs return to reset values. The partial result is discarded.
- in_valid and rst in the same cycle: rst wins, and the operands are not latched.

## Configuration
- ZERO_SKIP_EN:
  - Defined: RUN visits only nonzero nibbles, in ascending k.
    - RUN length = max(1, count of nonzero nibbles).
    - For wgt==0, RUN lasts one cycle adding 0, and product=0.
    - Latency = RUN length + 1.
  - Undefined: every nibble costs one RUN cycle, and latency is fixed at NUM_NIBBLES+1.
  - The product value is identical either way.

## Test plan
- act=3, wgt=0x1234, out_ready=1 → product=0x369C, approx=0, out_valid 5 cycles after accept (no macro).
- act=10, wgt=0x000B → product=120, approx=1. act=1, wgt=0xF9D0 → product=0xE8C0, approx=1.
- act=0xFFFF, wgt=0xEEEE → product=0xEEED1112, approx=0, with no truncation.
- act=0xFFFF, wgt=0 → product=0. Latency is 5 cycles without ZERO_SKIP_EN and 2 cycles with it. With the macro, wgt=0x0100 gives 2 cycles.
- Hold out_ready=0 for 6 cycles while pulsing in_valid:
  - out_valid, product and approx stay stable and in_ready stays 0.
  - New operands are accepted only after the out_ready handshake plus one cycle.
- Assert rst for 1 cycle at the second RUN cycle → the next cycle shows in_ready=1, out_valid=0, product=0. A following job computes correctly.

Source files
------------

// File: rtl/nibble_shift_sequencer.sv
// nibble_shift_sequencer: nibble-serial controller for the approximate
// alphabet-set multiplier. It takes one activation/weight pair per handshake.
// Each weight nibble is mapped to an alphabet {1,3,5,7} and a shift. One
// shift-and-accumulate step per nibble is applied to a 2*WIDTH accumulator.
// Optional build macro ZERO_SKIP_EN: when defined, RUN visits only the
// nonzero nibbles, so latency depends on the weight. The product is the same
// either way.
module nibble_shift_sequencer #(
  parameter int LOG2_WIDTH        = 4,
  parameter int WIDTH             = 2**LOG2_WIDTH,
  parameter int LOG2_NIBBLE_WIDTH = 2,
  parameter int NIBBLE_WIDTH      = 2**LOG2_NIBBLE_WIDTH,
  parameter int NUM_NIBBLES       = WIDTH/NIBBLE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      act,
  input  logic [WIDTH-1:0]      wgt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    product,
  output logic                  approx,
  output logic                  busy,
  output logic [LOG2_WIDTH-1:0] nib_idx
);

  localparam int AW  = 2*WIDTH;
  localparam int IXW = WIDTH+3;
  localparam int SW  = LOG2_WIDTH+2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [LOG2_WIDTH-1:0]   k, k_nxt;
  logic                    accept;

  logic [WIDTH-1:0]        act_q, wgt_q;
  logic [AW-1:0]           acc;
  logic                    approx_q;

  logic [NIBBLE_WIDTH-1:0] cur_nib;
  logic [5:0]              nib_map;
  logic                    nib_apx;
  logic [2:0]              alpha;
  logic [1:0]              sl;
  logic [IXW-1:0]          ix;
  logic [SW-1:0]           shamt;
  logic [AW-1:0]           addend;

  // Nibble -> {approximated, alpha, shift}. Values 9, 11, 13 and 15 have no
  // exact odd-alpha form and are rounded to the nearest representable value.
  function automatic logic [5:0] map_nibble(input logic [NIBBLE_WIDTH-1:0] v);
    logic [5:0] r;
    case (v)
      4'd0:    r = {1'b0, 3'd0, 2'd0};
      4'd1:    r = {1'b0, 3'd1, 2'd0};
      4'd2:    r = {1'b0, 3'd1, 2'd1};
      4'd3:    r = {1'b0, 3'd3, 2'd0};
      4'd4:    r = {1'b0, 3'd1, 2'd2};
      4'd5:    r = {1'b0, 3'd5, 2'd0};
      4'd6:    r = {1'b0, 3'd3, 2'd1};
      4'd7:    r = {1'b0, 3'd7, 2'd0};
      4'd8:    r = {1'b0, 3'd1, 2'd3};
      4'd9:    r = {1'b1, 3'd1, 2'd3};
      4'd10:   r = {1'b0, 3'd5, 2'd1};
      4'd11:   r = {1'b1, 3'd3, 2'd2};
      4'd12:   r = {1'b0, 3'd3, 2'd2};
      4'd13:   r = {1'b1, 3'd3, 2'd2};
      4'd14:   r = {1'b0, 3'd7, 2'd1};
      default: r = {1'b1, 3'd7, 2'd1};
    endcase
    return r;
  endfunction

`ifdef ZERO_SKIP_EN
  // Lowest nonzero nibble index >= from, with a found flag in the MSB.
  function automatic logic [LOG2_WIDTH:0] find_nz(input logic [WIDTH-1:0] w, input int from);
    logic [LOG2_WIDTH:0] r;
    r = '0;
    for (int i = NUM_NIBBLES-1; i >= 0; i--) begin
      if (i >= from && w[NIBBLE_WIDTH*i +: NIBBLE_WIDTH] != '0)
        r = {1'b1, LOG2_WIDTH'(i)};
    end
    return r;
  endfunction

  logic [LOG2_WIDTH:0] nz_first, nz_next;
  assign nz_first = find_nz(wgt, 0);
  assign nz_next  = find_nz(wgt_q, int'(k) + 1);
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = out_valid ? acc : '0;
  assign approx    = out_valid ? approx_q : 1'b0;
  assign nib_idx   = (state == RUN) ? k : '0;

  // Control state: FSM state and current nibble index
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Next-state and nibble-index sequencing
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
`ifdef ZERO_SKIP_EN
          k_nxt = nz_first[LOG2_WIDTH-1:0];
`else
          k_nxt = '0;
`endif
        end
      end
      RUN: begin
`ifdef ZERO_SKIP_EN
        if (nz_next[LOG2_WIDTH]) k_nxt = nz_next[LOG2_WIDTH-1:0];
        else                     state_nxt = DONE;
`else
        if (k == LOG2_WIDTH'(NUM_NIBBLES-1)) state_nxt = DONE;
        else                                 k_nxt = k + 1'b1;
`endif
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add step: alpha*act built from shifted copies, then placed at the
  // nibble position plus the alphabet shift
  always_comb begin
    cur_nib = wgt_q[NIBBLE_WIDTH*k +: NIBBLE_WIDTH];
    nib_map = map_nibble(cur_nib);
    nib_apx = nib_map[5];
    alpha   = nib_map[4:2];
    sl      = nib_map[1:0];
    ix      = (alpha[0] ? IXW'(act_q)         : '0)
            + (alpha[1] ? IXW'({act_q, 1'b0}) : '0)
            + (alpha[2] ? IXW'({act_q, 2'b0}) : '0);
    shamt   = (SW'(k) << LOG2_NIBBLE_WIDTH) + SW'(sl);
    addend  = AW'(ix) << shamt;
  end

  // Operand latch and accumulator; data is cleared on accept, not by reset
  always_ff @(posedge clk) begin
    if (accept) begin
      act_q    <= act;
      wgt_q    <= wgt;
      acc      <= '0;
      approx_q <= 1'b0;
    end else if (state == RUN) begin
      acc      <= acc + addend;
      approx_q <= approx_q | nib_apx;
    end
  end

endmodule

// File: tb/tb_nibble_shift_sequencer.sv
// Scoreboard bench for nibble_shift_sequencer: expected product, approx flag
// and latency are queued at stimulus time and checked when the DUT outputs.
module tb_nibble_shift_sequencer;

  localparam int W  = 16;
  localparam int NN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  act = '0;
  logic [W-1:0]  wgt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] product;
  logic          approx;
  logic          busy;
  logic [3:0]    nib_idx;

  nibble_shift_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .approx(approx), .busy(busy), .nib_idx(nib_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    logic           a;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] eff_nib(input logic [3:0] v);
    case (v)
      4'd9:         return 4'd8;
      4'd11, 4'd13: return 4'd12;
      4'd15:        return 4'd14;
      default:      return v;
    endcase
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] w);
    exp_t e;
    logic [W-1:0] effw;
    logic [3:0]   nb;
    int           nz;
    effw = '0;
    e.a  = 1'b0;
    nz   = 0;
    for (int i = 0; i < NN; i++) begin
      nb = w[4*i +: 4];
      effw[4*i +: 4] = eff_nib(nb);
      if (nb == 4'd9 || nb == 4'd11 || nb == 4'd13 || nb == 4'd15) e.a = 1'b1;
      if (nb != 4'd0) nz++;
    end
    e.p = (2*W)'(a) * (2*W)'(effw);
`ifdef ZERO_SKIP_EN
    e.lat = ((nz > 1) ? nz : 1) + 1;
`else
    e.lat = NN + 1;
`endif
    return e;
  endfunction

  // Monitor: record accept cycles, check outputs against the scoreboard head
  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) acc_cyc_q.push_back(cyc);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          if (acc_cyc_q.size() != 0) chk("latency", cyc - acc_cyc_q[0], exp_q[0].lat);
          else                       chk("accept_seen", 0, 1);
        end
        chk("product", product, exp_q[0].p);
        chk("approx", approx, exp_q[0].a);
        chk("in_ready_done", in_ready, 0);
        chk("busy_done", busy, 1);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (acc_cyc_q.size() != 0) void'(acc_cyc_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] w);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
    exp_q.push_back(model(a, w));
    act = a; wgt = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_cyc_q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_approx", approx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nib_idx", nib_idx, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors
    send(16'd3, 16'h1234);      wait_done();
    send(16'd10, 16'h000B);     wait_done();
    send(16'd1, 16'hF9D0);      wait_done();
    send(16'hFFFF, 16'hEEEE);   wait_done();
    send(16'hFFFF, 16'h0000);   wait_done();
    send(16'h1234, 16'h0100);   wait_done();
    send(16'hFFFF, 16'hFFFF);   wait_done();
    // Back-to-back without draining first
    send(16'd7, 16'h0009);
    send(16'd5, 16'h8000);      wait_done();

    // Output stall: out_ready low while in_valid pulses
    out_ready = 1'b0;
    send(16'h00AB, 16'h5A3C);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      if (!out_valid) chk("stall_wait", 0, 1);
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      act = W'($urandom);
      wgt = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    send(16'd2, 16'h0003);      wait_done();

    // Reset during the second RUN cycle
    send(16'd3, 16'h1234);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrun_in_ready", in_ready, 1);
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_product", product, 0);
    chk("midrun_busy", busy, 0);
    exp_q.delete();
    acc_cyc_q.delete();
    seen = 1'b0;
    send(16'd3, 16'h1234);      wait_done();

    // Random jobs
    for (int i = 0; i < 10; i++) begin
      send(W'($urandom), W'($urandom));
      wait_done();
    end

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
